// File: rtl/stack_op_sequencer.sv
// Stack instruction sequencer: expands one stack-machine instruction into the
// push/pop/overwrite strobes of the downstream data stack, refusing ops that
// would underflow or overflow it, and reports status and result to the issuer.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// PUSH  | stk_push/stk_data_write strobe cycle (PUSH, DUP)
// EXEC  | reg1 overwrite with the binary-op result
// POP   | stk_pop/stk_data_read strobe cycle (POP, binary ops)
// DONE  | done pulse, status/result/carry presented
module stack_op_sequencer #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 128,
    parameter int SIZE_W = 16
) (
    input  logic              clk,
    input  logic              async_reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_imm,
    input  logic [WIDTH-1:0]  stk_top,
    input  logic [WIDTH-1:0]  stk_second,
    input  logic [SIZE_W-1:0] stk_size,
    output logic              stk_push,
    output logic              stk_pop,
    output logic              stk_data_write,
    output logic              stk_data_read,
    output logic              stk_reg1_overwrite,
    output logic [WIDTH-1:0]  stk_reg0_in,
    output logic [WIDTH-1:0]  stk_reg1_in,
    output logic              done,
    output logic [1:0]        status,
    output logic [WIDTH-1:0]  result,
    output logic              carry
);

    typedef enum logic [2:0] {S_IDLE, S_PUSH, S_EXEC, S_POP, S_DONE} state_t;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_DUP  = 3'd2;
    localparam logic [2:0] OP_POP  = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;
    localparam logic [2:0] OP_AND  = 3'd6;
    localparam logic [2:0] OP_XOR  = 3'd7;

    localparam logic [1:0] ST_OK   = 2'd0;
    localparam logic [1:0] ST_UNDR = 2'd1;
    localparam logic [1:0] ST_OVFL = 2'd2;

    localparam logic [SIZE_W-1:0] SIZE_FULL = SIZE_W'(DEPTH - 1);
    localparam logic [SIZE_W-1:0] SIZE_TWO  = SIZE_W'(2);

    state_t             state_q, state_d;
    logic               push_q, push_d;
    logic               pop_q, pop_d;
    logic               ow_q, ow_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   reg0_q, reg0_d;
    logic [WIDTH-1:0]   reg1_q, reg1_d;
    logic [1:0]         status_q, status_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    // Result and carry captured at accept for ops that finish later.
    logic [WIDTH-1:0]   cap_val_q, cap_val_d;
    logic               cap_carry_q, cap_carry_d;

    logic               accept;
    logic [WIDTH:0]     sum_w, diff_w;
    logic [WIDTH-1:0]   acc_val;
    logic               acc_carry;
    logic [1:0]         acc_status;

    assign cmd_ready = (state_q == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // Decode the offered command against the live stack view (used only at accept).
    always_comb begin
        sum_w      = {1'b0, stk_second} + {1'b0, stk_top};
        diff_w     = {1'b0, stk_second} - {1'b0, stk_top};
        acc_val    = stk_top;
        acc_carry  = 1'b0;
        acc_status = ST_OK;
        case (cmd_op)
            OP_PUSH: begin
                acc_val = cmd_imm;
                if (stk_size >= SIZE_FULL) acc_status = ST_OVFL;
            end
            OP_DUP: begin
                if (stk_size >= SIZE_FULL) acc_status = ST_OVFL;
            end
            OP_POP: begin
                if (stk_size == '0) acc_status = ST_UNDR;
            end
            OP_ADD: begin
                acc_val   = sum_w[WIDTH-1:0];
                acc_carry = sum_w[WIDTH];
            end
            OP_SUB: begin
                acc_val   = diff_w[WIDTH-1:0];
                acc_carry = diff_w[WIDTH];
            end
            OP_AND:  acc_val = stk_second & stk_top;
            OP_XOR:  acc_val = stk_second ^ stk_top;
            default: ;
        endcase
        if (cmd_op >= OP_ADD && stk_size < SIZE_TWO) acc_status = ST_UNDR;
        // A refused op reports no carry.
        if (acc_status != ST_OK) acc_carry = 1'b0;
    end

    // State register plus all registered outputs; reset abandons any op in flight.
    always_ff @(posedge clk) begin
        if (async_reset) begin
            state_q     <= S_IDLE;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            ow_q        <= 1'b0;
            done_q      <= 1'b0;
            reg0_q      <= '0;
            reg1_q      <= '0;
            status_q    <= ST_OK;
            result_q    <= '0;
            carry_q     <= 1'b0;
            cap_val_q   <= '0;
            cap_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            push_q      <= push_d;
            pop_q       <= pop_d;
            ow_q        <= ow_d;
            done_q      <= done_d;
            reg0_q      <= reg0_d;
            reg1_q      <= reg1_d;
            status_q    <= status_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            cap_val_q   <= cap_val_d;
            cap_carry_q <= cap_carry_d;
        end
    end

    // Next-state: refused ops go straight to DONE without touching the stack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (acc_status != ST_OK || cmd_op == OP_NOP) state_d = S_DONE;
                    else if (cmd_op == OP_PUSH || cmd_op == OP_DUP) state_d = S_PUSH;
                    else if (cmd_op == OP_POP) state_d = S_POP;
                    else state_d = S_EXEC;
                end
            end
            S_PUSH:  state_d = S_DONE;
            S_EXEC:  state_d = S_POP;
            S_POP:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output next values, registered so each strobe lines up with its state.
    always_comb begin
        push_d      = (state_d == S_PUSH);
        pop_d       = (state_d == S_POP);
        ow_d        = (state_d == S_EXEC);
        done_d      = (state_d == S_DONE);
        reg0_d      = reg0_q;
        reg1_d      = reg1_q;
        status_d    = status_q;
        result_d    = result_q;
        carry_d     = carry_q;
        cap_val_d   = cap_val_q;
        cap_carry_d = cap_carry_q;
        if (accept) begin
            cap_val_d   = acc_val;
            cap_carry_d = acc_carry;
        end
        if (accept && state_d == S_PUSH) reg0_d = acc_val;
        if (accept && state_d == S_EXEC) reg1_d = acc_val;
        if (state_d == S_DONE) begin
            if (state_q == S_IDLE) begin
                status_d = acc_status;
                result_d = acc_val;
                carry_d  = acc_carry;
            end else begin
                status_d = ST_OK;
                result_d = cap_val_q;
                carry_d  = cap_carry_q;
            end
        end
    end

    assign stk_push           = push_q;
    assign stk_data_write     = push_q;
    assign stk_pop            = pop_q;
    assign stk_data_read      = pop_q;
    assign stk_reg1_overwrite = ow_q;
    assign stk_reg0_in        = reg0_q;
    assign stk_reg1_in        = reg1_q;
    assign done               = done_q;
    assign status             = status_q;
    assign result             = result_q;
    assign carry              = carry_q;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench for stack_op_sequencer: table of instruction vectors with a result
// scoreboard, plus hand-written reset-mid-op and held-valid sequences.
module tb_stack_op_sequencer;

    logic        clk = 1'b0;
    logic        async_reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_imm;
    logic [15:0] stk_top;
    logic [15:0] stk_second;
    logic [15:0] stk_size;
    logic        stk_push, stk_pop, stk_data_write, stk_data_read, stk_reg1_overwrite;
    logic [15:0] stk_reg0_in, stk_reg1_in;
    logic        done;
    logic [1:0]  status;
    logic [15:0] result;
    logic        carry;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stack_op_sequencer dut (
        .clk(clk), .async_reset(async_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_imm(cmd_imm),
        .stk_top(stk_top), .stk_second(stk_second), .stk_size(stk_size),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_write(stk_data_write),
        .stk_data_read(stk_data_read), .stk_reg1_overwrite(stk_reg1_overwrite),
        .stk_reg0_in(stk_reg0_in), .stk_reg1_in(stk_reg1_in),
        .done(done), .status(status), .result(result), .carry(carry)
    );

    typedef struct {
        logic [2:0]  op;
        logic [15:0] imm, top, sec, size;
        logic [1:0]  st;
        logic [15:0] res;
        logic        cy;
        logic        chkres;
        int          lat, npush, npop, now;
        logic [15:0] reg0, reg1;
    } vec_t;

    typedef struct {
        logic [1:0]  st;
        logic [15:0] res;
        logic        cy;
        logic        chkres;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [2:0] op, input logic [15:0] imm, top, sec, size,
                                 input logic [1:0] st, input logic [15:0] res, input logic cy,
                                 input logic chkres, input int lat, npush, npop, now,
                                 input logic [15:0] reg0, reg1);
        vec_t v;
        v.op = op; v.imm = imm; v.top = top; v.sec = sec; v.size = size;
        v.st = st; v.res = res; v.cy = cy; v.chkres = chkres;
        v.lat = lat; v.npush = npush; v.npop = npop; v.now = now;
        v.reg0 = reg0; v.reg1 = reg1;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int np = 0, npp = 0, now_ = 0, ndw = 0, ndr = 0, clash = 0, lat = 0;
        logic [15:0] r0 = '0, r1 = '0;
        exp_t e;
        @(negedge clk);
        cmd_op = v.op; cmd_imm = v.imm; stk_top = v.top; stk_second = v.sec; stk_size = v.size;
        cmd_valid = 1'b1;
        chk($sformatf("v%0d ready_before", idx), cmd_ready, 1);
        sb.push_back('{v.st, v.res, v.cy, v.chkres});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_imm = 16'($urandom); stk_top = 16'($urandom); stk_second = 16'($urandom);
        stk_size = 16'($urandom_range(0, 200));
        chk($sformatf("v%0d ready_busy", idx), cmd_ready, 0);
        for (int c = 1; c <= 8; c++) begin
            if (stk_push) begin np++; r0 = stk_reg0_in; end
            if (stk_reg1_overwrite) begin now_++; r1 = stk_reg1_in; end
            if (stk_pop) npp++;
            if (stk_data_write) ndw++;
            if (stk_data_read) ndr++;
            if (stk_push && stk_pop) clash++;
            if (done) begin lat = c; break; end
            @(posedge clk); #1;
        end
        chk($sformatf("v%0d latency", idx), lat, v.lat);
        if (lat != 0 && sb.size() != 0) begin
            e = sb.pop_front();
            chk($sformatf("v%0d status", idx), status, e.st);
            chk($sformatf("v%0d carry", idx), carry, e.cy);
            if (e.chkres) chk($sformatf("v%0d result", idx), result, e.res);
        end else if (sb.size() != 0) begin
            void'(sb.pop_front());
        end
        chk($sformatf("v%0d push_cnt", idx), np, v.npush);
        chk($sformatf("v%0d write_cnt", idx), ndw, v.npush);
        chk($sformatf("v%0d pop_cnt", idx), npp, v.npop);
        chk($sformatf("v%0d read_cnt", idx), ndr, v.npop);
        chk($sformatf("v%0d ow_cnt", idx), now_, v.now);
        chk($sformatf("v%0d push_pop_clash", idx), clash, 0);
        if (v.npush != 0) chk($sformatf("v%0d reg0_in", idx), r0, v.reg0);
        if (v.now != 0) chk($sformatf("v%0d reg1_in", idx), r1, v.reg1);
        @(posedge clk); #1;
        chk($sformatf("v%0d ready_after", idx), cmd_ready, 1);
        chk($sformatf("v%0d done_one_cycle", idx), done, 0);
        chk($sformatf("v%0d status_hold", idx), status, v.st);
    endtask

    initial begin
        int pops, dones, accs, pushes;
        //             op  imm       top       sec       size  st  res       cy ck lat pu po ow reg0      reg1
        vecs.push_back(mkv(1, 16'h1234, 16'h0000, 16'h0000, 0,   0, 16'h1234, 0, 1, 2, 1, 0, 0, 16'h1234, 16'h0));
        vecs.push_back(mkv(4, 16'h0000, 16'h0002, 16'hFFFF, 3,   0, 16'h0001, 1, 1, 3, 0, 1, 1, 16'h0,    16'h0001));
        vecs.push_back(mkv(5, 16'h0000, 16'h0005, 16'h0003, 2,   0, 16'hFFFE, 1, 1, 3, 0, 1, 1, 16'h0,    16'hFFFE));
        vecs.push_back(mkv(7, 16'h0000, 16'h00F0, 16'h0FF0, 5,   0, 16'h0F00, 0, 1, 3, 0, 1, 1, 16'h0,    16'h0F00));
        vecs.push_back(mkv(3, 16'h0000, 16'h1111, 16'h2222, 0,   1, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h0,    16'h0));
        vecs.push_back(mkv(4, 16'h0000, 16'h0001, 16'h0001, 1,   1, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h0,    16'h0));
        vecs.push_back(mkv(1, 16'hBEEF, 16'h0000, 16'h0000, 126, 0, 16'hBEEF, 0, 1, 2, 1, 0, 0, 16'hBEEF, 16'h0));
        vecs.push_back(mkv(1, 16'h5555, 16'h0000, 16'h0000, 127, 2, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h0,    16'h0));
        vecs.push_back(mkv(2, 16'h9999, 16'h4321, 16'h0000, 10,  0, 16'h4321, 0, 1, 2, 1, 0, 0, 16'h4321, 16'h0));
        vecs.push_back(mkv(0, 16'h0000, 16'h7777, 16'h0000, 0,   0, 16'h7777, 0, 1, 1, 0, 0, 0, 16'h0,    16'h0));
        vecs.push_back(mkv(3, 16'h0000, 16'hAAAA, 16'h0000, 4,   0, 16'hAAAA, 0, 1, 2, 0, 1, 0, 16'h0,    16'h0));
        vecs.push_back(mkv(6, 16'h0000, 16'hF0F0, 16'h3C3C, 2,   0, 16'h3030, 0, 1, 3, 0, 1, 1, 16'h0,    16'h3030));
        vecs.push_back(mkv(4, 16'h0000, 16'h0001, 16'h0002, 9,   0, 16'h0003, 0, 1, 3, 0, 1, 1, 16'h0,    16'h0003));
        vecs.push_back(mkv(5, 16'h0000, 16'h0003, 16'h0005, 9,   0, 16'h0002, 0, 1, 3, 0, 1, 1, 16'h0,    16'h0002));
        vecs.push_back(mkv(2, 16'h0000, 16'h6666, 16'h0000, 127, 2, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h0,    16'h0));
        vecs.push_back(mkv(4, 16'h0000, 16'h8000, 16'h8000, 2,   0, 16'h0000, 1, 1, 3, 0, 1, 1, 16'h0,    16'h0000));
        vecs.push_back(mkv(5, 16'h0000, 16'h0001, 16'h0001, 1,   1, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h0,    16'h0));

        async_reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_imm = '0;
        stk_top = '0; stk_second = '0; stk_size = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", cmd_ready, 1);
        chk("reset strobes", {stk_push, stk_pop, stk_data_write, stk_data_read, stk_reg1_overwrite, done}, 0);
        chk("reset status", status, 0);
        chk("reset result", result, 0);
        chk("reset carry", carry, 0);
        chk("reset reg_in", {stk_reg0_in, stk_reg1_in}, 0);
        @(negedge clk);
        async_reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Reset while in EXEC: the pending pop must never reach the stack.
        @(negedge clk);
        cmd_op = 3'd4; stk_top = 16'h0001; stk_second = 16'h0002; stk_size = 16'd5; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("rst_mid in_exec", stk_reg1_overwrite, 1);
        @(negedge clk);
        async_reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid ready", cmd_ready, 1);
        chk("rst_mid strobes", {stk_push, stk_pop, stk_reg1_overwrite, done}, 0);
        chk("rst_mid status", status, 0);
        @(negedge clk);
        async_reset = 1'b0;
        pops = 0; dones = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (stk_pop || stk_data_read) pops++;
            if (done) dones++;
        end
        chk("rst_mid pops", pops, 0);
        chk("rst_mid dones", dones, 0);

        // cmd_valid held through a busy op yields exactly one accept.
        @(negedge clk);
        cmd_op = 3'd1; cmd_imm = 16'h0BAD; stk_size = 16'd3; cmd_valid = 1'b1;
        accs = 0; pushes = 0; dones = 0;
        for (int c = 0; c < 6; c++) begin
            if (cmd_valid && cmd_ready) accs++;
            @(posedge clk); #1;
            if (stk_push) pushes++;
            if (done) begin
                dones++;
                chk("held result", result, 16'h0BAD);
                cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("held accepts", accs, 1);
        chk("held pushes", pushes, 1);
        chk("held dones", dones, 1);
        chk("scoreboard empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_op_sequencer.md
Name: stack_op_sequencer

Overview:
- Command front-end that sits directly upstream of the 128-entry data stack.
- Accepts one stack-machine instruction at a time over a valid/ready handshake and expands it into the stack's push, pop, data_read, data_write, reg1_overwrite and reg0_in/reg1_in strobes.
- Monitors the stack's size output so that underflow and overflow are refused before the stack is touched.
- Reports completion, status and the result word to the instruction issuer.

Parameters:
- WIDTH, 16, data word width; matches the stack cell width.
- DEPTH, 128, stack entries; push is refused when size >= DEPTH-1.
- SIZE_W, 16, width of the stack size input.

Ports:
- clk  in  1  rising-edge clock
- async_reset  in  1  reset; despite the name it is synchronous and active-high, sampled only on rising clk
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept; high only in IDLE
- cmd_op  in  3  0 NOP, 1 PUSH, 2 DUP, 3 POP, 4 ADD, 5 SUB, 6 AND, 7 XOR
- cmd_imm  in  WIDTH  immediate value for PUSH
- stk_top  in  WIDTH  stack reg0_out
- stk_second  in  WIDTH  stack reg1_out
- stk_size  in  SIZE_W  stack size
- stk_push  out  1  push strobe to stack
- stk_pop  out  1  pop strobe to stack
- stk_data_write  out  1  write qualifier, asserted together with stk_push
- stk_data_read  out  1  read qualifier, asserted together with stk_pop
- stk_reg1_overwrite  out  1  load stk_reg1_in into stack reg1
- stk_reg0_in  out  WIDTH  value pushed onto the top
- stk_reg1_in  out  WIDTH  value written into reg1
- done  out  1  one-cycle completion pulse
- status  out  2  0 OK, 1 UNDERFLOW, 2 OVERFLOW; held until the next done
- result  out  WIDTH  top-of-stack after the op; for POP, the popped value
- carry  out  1  ADD carry-out, SUB borrow; 0 for other ops

Behaviour:
- Reset (async_reset=1 at a clk edge):
  - state goes to IDLE.
  - All stk_* strobes, done, status, result and carry go to 0; stk_reg0_in and stk_reg1_in go to 0.
  - Reset mid-operation abandons the op; no strobe is asserted after that edge.
- Strobes are registered outputs, each asserted for exactly one cycle per op. stk_push never coincides with stk_pop.
- Handshake:
  - Accept occurs on a rising edge with cmd_valid && cmd_ready.
  - cmd_op, cmd_imm, stk_top, stk_second and stk_size are captured at accept.
  - cmd_ready drops the cycle after accept and returns with IDLE.
  - cmd_valid while busy is ignored and does not stall the sequencer.
- States: IDLE, PUSH, EXEC, POP, DONE.
- Transitions from IDLE on accept:
  - NOP -> DONE, status OK, result = captured top.
  - PUSH or DUP:
    - if captured size >= DEPTH-1 -> DONE, status OVERFLOW, no strobe;
    - else -> PUSH. stk_reg0_in = cmd_imm (PUSH) or captured top (DUP).
  - POP:
    - if size == 0 -> DONE, status UNDERFLOW;
    - else -> POP. result = captured top.
  - ADD, SUB, AND, XOR:
    - if size < 2 -> DONE, status UNDERFLOW;
    - else -> EXEC.
- PUSH state: stk_push = stk_data_write = 1 for one cycle, then DONE. result = pushed value.
- EXEC state:
  - Computes second OP top: ADD, SUB (second minus top), AND, XOR.
  - Arithmetic is modulo 2^WIDTH. carry = bit WIDTH of the (WIDTH+1)-bit sum, or the borrow for SUB.
  - Drives stk_reg1_in = value and stk_reg1_overwrite = 1 for one cycle, then POP.
  - result = computed value.
- POP state: stk_pop = stk_data_read = 1 for one cycle, then DONE. For binary ops, this pop exposes the overwritten reg1 as the new top.
- DONE state: done = 1 for one cycle, status and result valid, then IDLE.
- Latency from accept edge to done:
  - NOP and errors: 1 cycle.
  - PUSH, DUP, POP: 2 cycles.
  - Binary ops: 3 cycles.
- Throughput: next accept is possible in the cycle after done.
- Boundaries:
  - size == DEPTH-2 allows the push.
  - size == DEPTH-1 refuses it, so the stack's own overflow flag is never raised by this block.
  - Errors leave the stack untouched and cost no strobes.
  - stk_size is not re-sampled mid-op.

Test Plan:
- Reset, then PUSH imm=0x1234 -> stk_push/stk_data_write high 1 cycle with stk_reg0_in=0x1234; done 2 cycles after accept; status 0, result 0x1234.
- PUSH 0xFFFF, PUSH 0x0002, ADD -> one reg1_overwrite with stk_reg1_in=0x0001, then one pop; done at +3; result 0x0001, carry 1.
- Stack top=0x0005, second=0x0003, SUB -> result 0xFFFE, borrow 1; XOR of 0x00F0 and 0x0FF0 -> 0x0F00, carry 0.
- stk_size=0, POP -> done at +1 with status 1 and no strobes; stk_size=1, ADD -> status 1, no strobes.
- stk_size=126, PUSH -> push occurs; stk_size=127, PUSH -> status 2, no stk_push; DUP at size 10 -> stk_reg0_in = top.
- async_reset asserted in EXEC state -> next cycle IDLE, cmd_ready=1, stk_pop never asserted; cmd_valid held during a busy op -> exactly one accept.
